// File: rtl/spi_flash_responder_if.sv
// Synchronous byte-read port between the SPI flash responder and its backing store.
interface spi_flash_responder_if #(
  parameter int MEM_ADDR_W = 12
);
  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: answers READ (0x03) from a byte store and JEDEC ID (0x9F),
// with all SPI pins oversampled on the system clock.
module spi_flash_responder #(
  parameter int          MEM_ADDR_W  = 12,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SPI_CS,
  input  logic SPI_SCK,
  input  logic SPI_SI,
  output logic SPI_SO,
  output logic SPI_SO_OE,
  spi_flash_responder_if.master mem,
  output logic busy,
  output logic cmd_error
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, JEDEC, IGNORE} state_t;

  localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = 1;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync, flush_sr;
  logic cs_d, sck_d;
  logic cs_s, sck_s, si_s, flushed;
  logic sck_rise, sck_fall, cs_fall;

  state_t                state;
  logic [4:0]            bit_cnt;
  logic [23:0]           rx_shift;
  logic [23:0]           rx_next;
  logic [7:0]            tx_shift;
  logic [3:0]            tx_cnt;
  logic [7:0]            hold;
  logic [1:0]            jbyte;
  logic                  need_first;
  logic                  rd_dly;
  logic                  rd_en_q;
  logic [MEM_ADDR_W-1:0] addr_q;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign flushed  = flush_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // cs_d only records a high CS once the synchronizer holds real pin samples, so a CS
  // that is already low when reset releases never looks like a falling edge.
  assign cs_fall  = cs_d & ~cs_s;
  assign rx_next  = {rx_shift[22:0], si_s};

  assign busy          = (state != IDLE);
  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      si_sync  <= '0;
      flush_sr <= '0;
      cs_d     <= 1'b0;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], SPI_SI};
      flush_sr <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
      cs_d     <= flushed & cs_s;
      sck_d    <= sck_s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      tx_cnt     <= '0;
      hold       <= '0;
      jbyte      <= '0;
      need_first <= 1'b0;
      rd_dly     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      SPI_SO     <= 1'b0;
      SPI_SO_OE  <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      rd_en_q   <= 1'b0;
      if (cs_s) begin
        state      <= IDLE;
        SPI_SO     <= 1'b0;
        SPI_SO_OE  <= 1'b0;
        rd_dly     <= 1'b0;
        need_first <= 1'b0;
      end else if (cs_fall) begin
        state    <= CMD;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else begin
        case (state)
          CMD: if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (rx_next[7:0] == 8'h03) begin
                state <= ADDR;
              end else if (rx_next[7:0] == 8'h9F) begin
                state    <= JEDEC;
                tx_shift <= JEDEC_ID[23:16];
                tx_cnt   <= '0;
                jbyte    <= '0;
              end else begin
                state     <= IGNORE;
                cmd_error <= 1'b1;
              end
            end
          end
          ADDR: if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              state      <= DATA;
              rd_en_q    <= 1'b1;
              addr_q     <= rx_next[MEM_ADDR_W-1:0];
              need_first <= 1'b1;
            end
          end
          DATA: begin
            rd_dly <= rd_en_q;
            // The first returned byte goes straight to the shifter; later ones wait in hold.
            if (rd_dly) begin
              if (need_first) begin
                tx_shift   <= mem.mem_rdata;
                tx_cnt     <= '0;
                need_first <= 1'b0;
                rd_en_q    <= 1'b1;
                addr_q     <= addr_q + ADDR_ONE;
              end else begin
                hold <= mem.mem_rdata;
              end
            end
            if (sck_fall) begin
              SPI_SO_OE <= 1'b1;
              if (tx_cnt != 4'd8) begin
                SPI_SO   <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                tx_cnt   <= tx_cnt + 4'd1;
              end else begin
                SPI_SO   <= hold[7];
                tx_shift <= {hold[6:0], 1'b0};
                tx_cnt   <= 4'd1;
                rd_en_q  <= 1'b1;
                addr_q   <= addr_q + ADDR_ONE;
              end
            end
          end
          JEDEC: if (sck_fall) begin
            if (tx_cnt != 4'd8) begin
              SPI_SO    <= tx_shift[7];
              SPI_SO_OE <= 1'b1;
              tx_shift  <= {tx_shift[6:0], 1'b0};
              tx_cnt    <= tx_cnt + 4'd1;
            end else if (jbyte != 2'd2) begin
              SPI_SO    <= (jbyte == 2'd0) ? JEDEC_ID[15] : JEDEC_ID[7];
              SPI_SO_OE <= 1'b1;
              tx_shift  <= (jbyte == 2'd0) ? {JEDEC_ID[14:8], 1'b0} : {JEDEC_ID[6:0], 1'b0};
              tx_cnt    <= 4'd1;
              jbyte     <= jbyte + 2'd1;
            end else begin
              SPI_SO    <= 1'b0;
              SPI_SO_OE <= 1'b0;
            end
          end
          default: begin
            SPI_SO    <= 1'b0;
            SPI_SO_OE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus queues expected SO bytes, memory
// addresses and per-transaction summaries; independent monitors pop and compare them.
module tb_spi_flash_responder;

  typedef struct {
    int oe_bits;
    int err_pulses;
  } txn_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SPI_CS = 1'b1;
  logic SPI_SCK = 1'b0;
  logic SPI_SI = 1'b0;
  logic SPI_SO, SPI_SO_OE, busy, cmd_error;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_bytes[$];
  logic [11:0] exp_addr[$];
  txn_t        exp_txn[$];

  spi_flash_responder_if #(.MEM_ADDR_W(12)) mem_if ();

  spi_flash_responder #(.MEM_ADDR_W(12), .JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_SI(SPI_SI),
    .SPI_SO(SPI_SO), .SPI_SO_OE(SPI_SO_OE), .mem(mem_if.master),
    .busy(busy), .cmd_error(cmd_error)
  );

  always #5 CLK = ~CLK;

  // Backing store: byte[a] = a[7:0] ^ 0x5A, one cycle read latency.
  always @(posedge CLK) begin
    if (mem_if.mem_rd_en) mem_if.mem_rdata <= mem_if.mem_addr[7:0] ^ 8'h5A;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic flag_missing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got nothing expected, expected an entry", name);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic apply_stimulus(input int n_bits, input int half, input bit end_cs);
    logic [7:0] v;
    int byte_idx;
    SPI_CS = 1'b0;
    wait_clk(half);
    for (int i = 0; i < n_bits; i++) begin
      byte_idx = i / 8;
      v = (byte_idx < tx_q.size()) ? tx_q[byte_idx] : 8'h00;
      SPI_SI = v[7 - (i % 8)];
      wait_clk(half);
      SPI_SCK = 1'b1;
      wait_clk(half);
      if (i != n_bits - 1) SPI_SCK = 1'b0;
    end
    if (end_cs) begin
      SPI_CS = 1'b1;
      wait_clk(half);
      SPI_SCK = 1'b0;
      wait_clk(half);
    end
  endtask

  task automatic end_txn(input int half);
    SPI_CS = 1'b1;
    wait_clk(half);
    SPI_SCK = 1'b0;
    wait_clk(half);
  endtask

  task automatic sck_cycles(input int n, input int half);
    for (int k = 0; k < n; k++) begin
      SPI_SCK = 1'b0;
      wait_clk(half);
      SPI_SCK = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic push_txn(input int oe_bits, input int errs);
    txn_t t;
    t.oe_bits = oe_bits;
    t.err_pulses = errs;
    exp_txn.push_back(t);
  endtask

  always @(negedge CLK) begin
    if (cmd_error) err_pulses++;
  end

  // Memory-address scoreboard.
  initial begin : addr_monitor
    forever begin
      @(negedge CLK);
      if (mem_if.mem_rd_en === 1'b1) begin
        if (exp_addr.size() == 0) flag_missing("mem_addr_unexpected_read");
        else check_output("mem_addr", {20'd0, mem_if.mem_addr}, {20'd0, exp_addr.pop_front()});
      end
    end
  end

  // SO scoreboard: bits are taken on the master's SCK rise, bytes compared as they complete.
  initial begin : so_monitor
    logic [7:0] cur_byte;
    int cur_bits, oe_bits, stray, err_base;
    bit in_txn;
    txn_t t;
    cur_byte = '0; cur_bits = 0; oe_bits = 0; stray = 0; err_base = 0; in_txn = 0;
    forever begin
      @(posedge SPI_SCK or posedge SPI_CS);
      if (SPI_CS === 1'b1) begin
        if (in_txn) begin
          if (exp_txn.size() == 0) flag_missing("txn_unexpected");
          else begin
            t = exp_txn.pop_front();
            check_output("oe_bit_count", oe_bits, t.oe_bits);
            check_output("cmd_error_pulses", err_pulses - err_base, t.err_pulses);
            check_output("so_nonzero_while_oe_low", stray, 0);
          end
          in_txn = 0; cur_bits = 0; oe_bits = 0; stray = 0;
        end
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          err_base = err_pulses;
        end
        if (SPI_SO_OE === 1'b1) begin
          cur_byte = {cur_byte[6:0], SPI_SO};
          cur_bits++;
          oe_bits++;
          if (cur_bits == 8) begin
            cur_bits = 0;
            if (exp_bytes.size() == 0) flag_missing("so_byte_unexpected");
            else check_output("so_byte", {24'd0, cur_byte}, {24'd0, exp_bytes.pop_front()});
          end
        end else if (SPI_SO !== 1'b0) begin
          stray++;
        end
      end
    end
  end

  initial begin
    wait_clk(3);
    check_output("reset_so", {31'd0, SPI_SO}, 0);
    check_output("reset_oe", {31'd0, SPI_SO_OE}, 0);
    check_output("reset_busy", {31'd0, busy}, 0);
    check_output("reset_cmd_error", {31'd0, cmd_error}, 0);
    check_output("reset_rd_en", {31'd0, mem_if.mem_rd_en}, 0);
    RST_N = 1'b1;
    wait_clk(5);

    // READ 0x000010, 4 bytes
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10};
    exp_bytes = {exp_bytes, 8'h4A, 8'h4B, 8'h48, 8'h49};
    exp_addr = {exp_addr, 12'h010, 12'h011, 12'h012, 12'h013, 12'h014};
    push_txn(32, 0);
    apply_stimulus(64, 4, 1);

    // READ across the top of the store
    tx_q = {8'h03, 8'h00, 8'h0F, 8'hFE};
    exp_bytes = {exp_bytes, 8'hA4, 8'hA5, 8'h5A};
    exp_addr = {exp_addr, 12'hFFE, 12'hFFF, 12'h000, 12'h001};
    push_txn(24, 0);
    apply_stimulus(56, 5, 1);

    // High address bits are ignored
    tx_q = {8'h03, 8'h12, 8'h34, 8'h56};
    exp_bytes = {exp_bytes, 8'h0C, 8'h0D};
    exp_addr = {exp_addr, 12'h456, 12'h457, 12'h458};
    push_txn(16, 0);
    apply_stimulus(48, 4, 1);

    // JEDEC ID then 16 idle clocks
    tx_q = {8'h9F};
    exp_bytes = {exp_bytes, 8'hEF, 8'h40, 8'h16};
    push_txn(24, 0);
    apply_stimulus(48, 4, 1);

    // Unsupported opcode
    tx_q = {8'h05};
    push_txn(0, 1);
    apply_stimulus(24, 4, 0);
    check_output("ignore_busy_held", {31'd0, busy}, 1);
    end_txn(4);
    check_output("ignore_busy_released", {31'd0, busy}, 0);

    // Aborted address phase, then a clean READ of 0x000020
    tx_q = {8'h03, 8'hAB, 8'hCD, 8'hEF};
    push_txn(0, 0);
    apply_stimulus(20, 4, 1);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h20};
    exp_bytes = {exp_bytes, 8'h7A};
    exp_addr = {exp_addr, 12'h020, 12'h021};
    push_txn(8, 0);
    apply_stimulus(40, 4, 1);

    // Reset mid-DATA with CS held low
    tx_q = {8'h03, 8'h00, 8'h00, 8'h30};
    exp_bytes = {exp_bytes, 8'h6A, 8'h6B};
    exp_addr = {exp_addr, 12'h030, 12'h031, 12'h032};
    push_txn(16, 0);
    apply_stimulus(48, 4, 0);
    RST_N = 1'b0;
    #1;
    check_output("midreset_so", {31'd0, SPI_SO}, 0);
    check_output("midreset_oe", {31'd0, SPI_SO_OE}, 0);
    check_output("midreset_busy", {31'd0, busy}, 0);
    check_output("midreset_rd_en", {31'd0, mem_if.mem_rd_en}, 0);
    check_output("midreset_addr", {20'd0, mem_if.mem_addr}, 0);
    wait_clk(3);
    RST_N = 1'b1;
    sck_cycles(16, 4);
    check_output("postreset_busy", {31'd0, busy}, 0);
    end_txn(4);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h40};
    exp_bytes = {exp_bytes, 8'h1A, 8'h1B};
    exp_addr = {exp_addr, 12'h040, 12'h041, 12'h042};
    push_txn(16, 0);
    apply_stimulus(48, 4, 1);

    // 16-byte READ at the minimum SCK half-period
    tx_q = {8'h03, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 16; i++) begin
      exp_bytes.push_back(8'(i) ^ 8'h5A);
      exp_addr.push_back(12'h100 + 12'(i));
    end
    exp_addr.push_back(12'h110);
    push_txn(128, 0);
    apply_stimulus(160, 4, 1);

    wait_clk(10);
    check_output("bytes_left_unseen", exp_bytes.size(), 0);
    check_output("addrs_left_unseen", exp_addr.size(), 0);
    check_output("txns_left_unseen", exp_txn.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI slave that emulates the serial flash seen by the CPU-side SPI controller: it decodes READ (0x03) and JEDEC ID (0x9F) commands and streams bytes back on SO.
- Backing bytes come from an external synchronous byte-read port, e.g. a block RAM preloaded with the program image.
- Used as the flash model in simulation and as an on-FPGA flash replacement.
- SPI pins are oversampled on the single system clock; no SCK-domain logic.

Parameters:
- MEM_ADDR_W, 12, byte-address width of the backing store; SPI address bits above it are ignored (the address wraps modulo 2^MEM_ADDR_W).
- JEDEC_ID, 24'hEF4016, the three bytes returned for 0x9F, MSB byte first.
- SYNC_STAGES, 2, synchronizer depth on SPI_CS, SPI_SCK and SPI_SI (minimum 2).

Ports:
- CLK  in  1  system clock (all logic on posedge).
- RST_N  in  1  asynchronous, active-low reset.
- SPI_CS  in  1  chip select, active low.
- SPI_SCK  in  1  SPI clock, mode 0 (idle low).
- SPI_SI  in  1  master-out data, MSB first.
- SPI_SO  out  1  slave-out data.
- SPI_SO_OE  out  1  high while SO carries valid data (READ or JEDEC data phase).
- mem_rd_en  out  1  one-cycle read strobe to the backing store.
- mem_addr  out  MEM_ADDR_W  byte address for the read.
- mem_rdata  in  8  read data, valid exactly 1 CLK after mem_rd_en.
- busy  out  1  high whenever the state is not IDLE.
- cmd_error  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset (async assert, sync release): all outputs are 0.
  - state=IDLE; synchronized CS resets to 1; synchronized SCK and SI reset to 0.
  - Shift registers, bit counter and address register are cleared.
- Edge detection: sck_rise and sck_fall are single-cycle pulses derived from the last two synchronized SCK samples. SI is sampled on sck_rise; SO changes only on sck_fall.
- Timing requirement: SCK high and low phases are each ≥4 CLK cycles. Behaviour below that is undefined.
- A synchronized CS falling edge forces state=CMD and bit_cnt=0.
- A synchronized CS high forces IDLE from any state, next CLK. This discards any partial byte, drops any pending prefetch, and sets SO=0 and OE=0.
- States:
  - IDLE: wait for CS low.
  - CMD: shift 8 bits on sck_rise. After the 8th bit: 0x03 → ADDR; 0x9F → JEDEC; anything else → IGNORE with cmd_error=1 for one cycle.
  - ADDR: shift 24 bits. On the cycle after the 24th sck_rise, issue mem_rd_en=1 with mem_addr = addr[MEM_ADDR_W-1:0], then go to DATA.
  - DATA:
    - The returned byte loads tx_shift; a prefetch read of addr+1 is issued immediately into a 1-byte holding register.
    - On each sck_fall: SO = tx_shift[7], then tx_shift shifts left.
    - After the 8th bit of a byte has been driven, the next sck_fall loads the holding byte and drives its MSB, then issues the next prefetch.
    - The address increments modulo 2^MEM_ADDR_W, so 0xFFF wraps to 0x000.
    - The stream continues until CS goes high.
  - JEDEC: same shifting as DATA, but the source is JEDEC_ID bytes 2,1,0. After the 3rd byte SO=0 and OE=0 until CS goes high.
  - IGNORE: SO=0, OE=0, SI is discarded until CS goes high.
- First data bit: SO becomes valid after the first sck_fall following the 32nd sck_rise. OE rises on the same CLK edge.
- Latency from the 24th address sck_rise to tx_shift loaded is 2 CLK, which is inside the ≥4-cycle high phase.
- If sck_rise or sck_fall coincides with CS going high, the CS release wins.
- Reset asserted mid-transfer behaves exactly as the reset values above. After release, the responder waits for a fresh CS falling edge; a CS already low at release is not treated as a new transaction.

Test Plan:
- Memory byte[a] = a[7:0]^0x5A. Send CS low, 0x03, address 0x000010, then read 4 bytes → SO bytes 0x4A,0x4B,0x48,0x49; OE high only during the data bits; mem_addr sequence 0x010,0x011,0x012,0x013,0x014.
- READ at address 0x000FFE with 3 bytes → bytes from addresses 0xFFE, 0xFFF, 0x000 (0xA4, 0xA5, 0x5A).
- Address 0x123456 with MEM_ADDR_W=12 → first byte read from 0x456.
- 0x9F followed by 40 SCK cycles → SO bytes 0xEF, 0x40, 0x16, then SO=0 with OE=0 for the remaining 16 clocks.
- Opcode 0x05 → cmd_error pulses exactly once after the 8th sck_rise; SO stays 0 and OE stays 0 for 16 further SCK cycles; busy=1 until CS goes high.
- CS raised after 12 address bits, then a full READ of 0x000020 → the first byte is 0x7A; no stale address bits carry over.
- RST_N pulsed low mid-DATA → all outputs 0 within the same cycle. After release with CS still low, SCK toggling produces no output; the next CS cycle performs a normal READ.
- SCK half-period of exactly 4 CLK with SYNC_STAGES=2 → zero bit errors across a 16-byte READ.
